// File: rtl/chunked_compare_unit.sv
// Multi-cycle branch-condition comparator: walks the operands CHUNK_BITS at a time
// from the MSB and stops at the first differing chunk.
module chunked_compare_unit #(
    parameter int NUM_BITS   = 32,
    parameter int CHUNK_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] data1,
    input  logic [NUM_BITS-1:0] data2,
    input  logic [2:0]          op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                equal,
    output logic                not_equal,
    output logic                taken,
    output logic                illegal_op
);
    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int IW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_BITS-1:0] MSB_M = CHUNK_BITS'(1) << (CHUNK_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (CHUNK_BITS < 1 || (NUM_BITS % CHUNK_BITS) != 0) begin : g_bad_chunk
        $error("chunked_compare_unit: CHUNK_BITS must divide NUM_BITS");
    end

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_BITS-1:0]   a_q, b_q;
    logic [2:0]            op_q;
    logic                  equal_q, not_equal_q, taken_q, illegal_q;
    logic                  equal_d, not_equal_d, taken_d, illegal_d;
    logic [CHUNK_BITS-1:0] c1, c2;
    logic                  differ, top, lt_u, lt_s, finish, accept;

    always_comb begin
        c1 = '0;
        c2 = '0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            if (idx_q == IW'(c)) begin
                c1 = a_q[c*CHUNK_BITS +: CHUNK_BITS];
                c2 = b_q[c*CHUNK_BITS +: CHUNK_BITS];
            end
        end
    end

    // The top chunk carries the sign bit; flipping both MSBs turns the signed
    // ordering into an unsigned one for that chunk only.
    assign top    = (idx_q == IW'(NUM_CHUNKS - 1));
    assign differ = (c1 != c2);
    assign lt_u   = differ && (c1 < c2);
    assign lt_s   = differ && (top ? ((c1 ^ MSB_M) < (c2 ^ MSB_M)) : (c1 < c2));
    assign finish = (state_q == S_CMP) && (differ || idx_q == '0);
    assign accept = in_valid && in_ready;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        equal_d     = equal_q;
        not_equal_d = not_equal_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_CMP;
                idx_d   = IW'(NUM_CHUNKS - 1);
            end
            S_CMP: if (finish) begin
                state_d     = S_DONE;
                equal_d     = ~differ;
                not_equal_d = differ;
                illegal_d   = (op_q[2:1] == 2'b01);
                case (op_q)
                    3'b000:  taken_d = ~differ;
                    3'b001:  taken_d = differ;
                    3'b100:  taken_d = lt_s;
                    3'b101:  taken_d = ~lt_s;
                    3'b110:  taken_d = lt_u;
                    3'b111:  taken_d = ~lt_u;
                    default: taken_d = 1'b0;
                endcase
            end else begin
                idx_d = idx_q - IW'(1);
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            equal_q     <= 1'b0;
            not_equal_q <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            equal_q     <= equal_d;
            not_equal_q <= not_equal_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
        end
    end

    // Operands need no reset; they are only read after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= data1;
            b_q  <= data2;
            op_q <= op;
        end
    end

    assign equal      = equal_q;
    assign not_equal  = not_equal_q;
    assign taken      = taken_q;
    assign illegal_op = illegal_q;
endmodule
